// File: rtl/lcd_pkg.sv
// Shared types, op codes and command constants for the LCD sequencer.
package lcd_pkg;

  localparam int unsigned ENTRY_W   = 11;
  localparam int unsigned PAYLOAD_W = 9;

  typedef enum logic [1:0] {
    OP_IDX = 2'b00,
    OP_DAT = 2'b01,
    OP_DLY = 2'b10,
    OP_END = 2'b11
  } op_t;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [3:0] {
    RST_DLY,
    FETCH,
    I_ISSUE,
    I_WAIT,
    I_DELAY,
    READY,
    W_ISSUE,
    W_WAIT,
    P_IN,
    P_HI,
    P_HI_WAIT,
    P_LO,
    P_LO_WAIT
  } state_t;

  // Pack an init ROM entry.
  function automatic logic [ENTRY_W-1:0] rom_entry(input op_t op, input logic [PAYLOAD_W-1:0] payload);
    return {op, payload};
  endfunction

  // Window words 0, 5 and 10 are commands; the rest are data.
  function automatic logic win_is_data(input logic [3:0] i);
    return !(i == 4'd0 || i == 4'd5 || i == 4'd10);
  endfunction

  // Byte for window word i; coordinates are sent high byte first.
  function automatic logic [7:0] win_byte(input logic [3:0] i, input logic [15:0] a0, input logic [15:0] a1,
                                          input logic [15:0] b0, input logic [15:0] b1);
    logic [7:0] r;
    case (i)
      4'd0:    r = CMD_CASET;
      4'd1:    r = a0[15:8];
      4'd2:    r = a0[7:0];
      4'd3:    r = a1[15:8];
      4'd4:    r = a1[7:0];
      4'd5:    r = CMD_PASET;
      4'd6:    r = b0[15:8];
      4'd7:    r = b0[7:0];
      4'd8:    r = b1[15:8];
      4'd9:    r = b1[7:0];
      default: r = CMD_RAMWR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Panel init script: software reset, settle delay, sleep out, one parameter byte.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int unsigned ROM_AW = 6
) (
  input  logic [ROM_AW-1:0]  addr,
  output logic [ENTRY_W-1:0] entry
);

  // Combinational script lookup; unused addresses read as end of script.
  always_comb begin
    case (addr)
      ROM_AW'(0): entry = rom_entry(OP_IDX, 9'h001);
      ROM_AW'(1): entry = rom_entry(OP_DLY, 9'd2);
      ROM_AW'(2): entry = rom_entry(OP_IDX, 9'h011);
      ROM_AW'(3): entry = rom_entry(OP_DAT, 9'h005);
      default:    entry = rom_entry(OP_END, 9'h000);
    endcase
  end

endmodule

// File: rtl/lcd_ctrl.sv
// LCD sequencer: plays the init script, then writes windows of RGB565 pixels through the SPI driver.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned COORD_W    = 8,
  parameter int unsigned RST_WAIT   = 1000,
  parameter int unsigned DLY_UNIT   = 1000,
  parameter int unsigned ROM_AW     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  output logic                  busy,
  input  logic                  frame_req,
  input  logic [COORD_W-1:0]    x0,
  input  logic [COORD_W-1:0]    x1,
  input  logic [COORD_W-1:0]    y0,
  input  logic [COORD_W-1:0]    y1,
  output logic                  frame_ack,
  output logic                  frame_err,
  output logic                  frame_done,
  input  logic                  pix_valid,
  input  logic [15:0]           pix_data,
  output logic                  pix_ready,
  output logic                  drv_valid,
  output logic                  drv_index_or_data,
  output logic [DATA_WIDTH-1:0] drv_data,
  input  logic                  drv_done
);

  localparam int unsigned PIX_W   = 2 * COORD_W + 1;
  localparam int unsigned DLY_MAX = 511 * DLY_UNIT;
  localparam int unsigned CNT_MAX = (DLY_MAX > RST_WAIT) ? DLY_MAX : RST_WAIT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t               state;
  logic [ROM_AW-1:0]    ptr;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     dly_tgt;
  logic [3:0]           widx;
  logic [PIX_W-1:0]     pcount;
  logic [7:0]           pix_lo;
  logic [COORD_W-1:0]   x0_q, x1_q, y0_q, y1_q;

  logic [ENTRY_W-1:0]   rom_word;
  op_t                  rom_op;
  logic [PAYLOAD_W-1:0] rom_payload;

  logic [COORD_W:0]     wdt, hgt;
  logic [PIX_W-1:0]     frame_pix;
  logic                 win_bad;
  logic [3:0]           widx_nxt;

  lcd_init_rom #(.ROM_AW(ROM_AW)) u_rom (
    .addr  (ptr),
    .entry (rom_word)
  );

  assign rom_op      = op_t'(rom_word[ENTRY_W-1:PAYLOAD_W]);
  assign rom_payload = rom_word[PAYLOAD_W-1:0];

  // Window legality and pixel count from the live request coordinates.
  assign win_bad   = (x1 < x0) || (y1 < y0);
  assign wdt       = {1'b0, x1} - {1'b0, x0} + (COORD_W + 1)'(1);
  assign hgt       = {1'b0, y1} - {1'b0, y0} + (COORD_W + 1)'(1);
  assign frame_pix = PIX_W'(wdt) * PIX_W'(hgt);
  assign widx_nxt  = widx + 4'd1;

  // Sequencer FSM with registered outputs; one driver transaction outstanding at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= RST_DLY;
      ptr               <= '0;
      cnt               <= '0;
      dly_tgt           <= '0;
      widx              <= '0;
      pcount            <= '0;
      pix_lo            <= '0;
      x0_q              <= '0;
      x1_q              <= '0;
      y0_q              <= '0;
      y1_q              <= '0;
      init_done         <= 1'b0;
      busy              <= 1'b0;
      frame_ack         <= 1'b0;
      frame_err         <= 1'b0;
      frame_done        <= 1'b0;
      pix_ready         <= 1'b0;
      drv_valid         <= 1'b0;
      drv_index_or_data <= 1'b0;
      drv_data          <= '0;
    end else begin
      drv_valid  <= 1'b0;
      frame_ack  <= 1'b0;
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        RST_DLY: begin
          busy <= 1'b1;
          if (cnt == CNT_W'(RST_WAIT - 1)) begin
            cnt   <= '0;
            state <= FETCH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FETCH: begin
          case (rom_op)
            OP_IDX, OP_DAT: begin
              drv_valid         <= 1'b1;
              drv_index_or_data <= (rom_op == OP_DAT);
              drv_data          <= DATA_WIDTH'(rom_payload);
              state             <= I_ISSUE;
            end
            OP_DLY: begin
              dly_tgt <= CNT_W'(32'(rom_payload) * DLY_UNIT);
              cnt     <= '0;
              state   <= I_DELAY;
            end
            default: begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state     <= READY;
            end
          endcase
        end
        I_ISSUE: state <= I_WAIT;
        I_WAIT: begin
          if (drv_done) begin
            if (ptr == '1) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state     <= READY;
            end else begin
              ptr   <= ptr + ROM_AW'(1);
              state <= FETCH;
            end
          end
        end
        I_DELAY: begin
          if (dly_tgt == '0 || cnt == dly_tgt - CNT_W'(1)) begin
            cnt <= '0;
            if (ptr == '1) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state     <= READY;
            end else begin
              ptr   <= ptr + ROM_AW'(1);
              state <= FETCH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        READY: begin
          if (frame_req) begin
            frame_ack <= 1'b1;
            x0_q      <= x0;
            x1_q      <= x1;
            y0_q      <= y0;
            y1_q      <= y1;
            if (win_bad) begin
              frame_err <= 1'b1;
            end else begin
              pcount            <= frame_pix;
              widx              <= '0;
              busy              <= 1'b1;
              drv_valid         <= 1'b1;
              drv_index_or_data <= 1'b0;
              drv_data          <= DATA_WIDTH'(CMD_CASET);
              state             <= W_ISSUE;
            end
          end
        end
        W_ISSUE: state <= W_WAIT;
        W_WAIT: begin
          if (drv_done) begin
            if (widx == 4'd10) begin
              pix_ready <= 1'b1;
              state     <= P_IN;
            end else begin
              widx              <= widx_nxt;
              drv_valid         <= 1'b1;
              drv_index_or_data <= win_is_data(widx_nxt);
              drv_data          <= DATA_WIDTH'(win_byte(widx_nxt, 16'(x0_q), 16'(x1_q), 16'(y0_q), 16'(y1_q)));
              state             <= W_ISSUE;
            end
          end
        end
        P_IN: begin
          if (pix_valid) begin
            pix_lo            <= pix_data[7:0];
            pix_ready         <= 1'b0;
            drv_valid         <= 1'b1;
            drv_index_or_data <= 1'b1;
            drv_data          <= DATA_WIDTH'(pix_data[15:8]);
            state             <= P_HI;
          end
        end
        P_HI: state <= P_HI_WAIT;
        P_HI_WAIT: begin
          if (drv_done) begin
            drv_valid <= 1'b1;
            drv_data  <= DATA_WIDTH'(pix_lo);
            state     <= P_LO;
          end
        end
        P_LO: state <= P_LO_WAIT;
        P_LO_WAIT: begin
          if (drv_done) begin
            pcount <= pcount - PIX_W'(1);
            if (pcount == PIX_W'(1)) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= READY;
            end else begin
              pix_ready <= 1'b1;
              state     <= P_IN;
            end
          end
        end
        default: state <= RST_DLY;
      endcase
    end
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Sequencer in front of the SPI LCD driver (lcd_driver); the only block that drives that driver.
- After reset, plays a panel init script from a ROM, including command words, data words and timed delays.
- Afterwards serves frame-write requests: programs the column/row window, then streams RGB565 pixels from a valid/ready source as byte pairs.
- Issues exactly one driver transaction at a time and waits for the driver's done pulse.

Parameters:
- DATA_WIDTH, 9, driver word width. Bytes are zero-extended into it.
- COORD_W, 8, width of window coordinates.
- RST_WAIT, 1000, cycles idle after reset before the first ROM fetch.
- DLY_UNIT, 1000, cycles per delay-count unit in a ROM delay entry.
- ROM_AW, 6, init ROM address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- init_done  out  1  high once the init script has finished; stays high until reset
- busy  out  1  high in every state except READY
- frame_req  in  1  level request for a window write
- x0, x1, y0, y1  in  COORD_W each  inclusive window bounds; sampled when frame_req is accepted
- frame_ack  out  1  one-cycle pulse on acceptance
- frame_err  out  1  one-cycle pulse, coincident with frame_ack, when the window is illegal
- frame_done  out  1  one-cycle pulse after the last pixel's done
- pix_valid  in  1  pixel source valid
- pix_data  in  16  RGB565 pixel
- pix_ready  out  1  pixel accepted when pix_valid and pix_ready are both high
- drv_valid  out  1  one-cycle transaction start to the driver
- drv_index_or_data  out  1  0 = index word, 1 = data word
- drv_data  out  DATA_WIDTH  word to send
- drv_done  in  1  driver completion pulse

Behaviour:
- Reset (Already decided): one clock; reset is asynchronous and active-high.
- While reset is asserted, all outputs are 0, the ROM pointer is 0 and the state is RST_DLY. Reset mid-operation abandons any transfer; init re-runs from entry 0.
- Init ROM entry format: 11 bits, op = [10:9], payload = [8:0].
  - op 00: index word
  - op 01: data word
  - op 10: delay of payload×DLY_UNIT cycles; payload 0 = no wait
  - op 11: end of script
- Driver handshake:
  - In an ISSUE state, drv_valid is high for exactly one cycle. drv_index_or_data and drv_data are held stable from that cycle until drv_done.
  - The FSM then waits in WAIT for drv_done.
  - The next drv_valid comes no earlier than the cycle after drv_done.
  - drv_valid must never be asserted while a transaction is outstanding.
  - With the standard driver, drv_done arrives 29 cycles after drv_valid, giving 30 cycles per word.
- State machine:
  - RST_DLY → FETCH after RST_WAIT cycles.
  - FETCH: read ROM at the pointer.
    - op 00/01 → I_ISSUE
    - op 10 → I_DELAY
    - op 11 → READY, and init_done is set
  - I_ISSUE → I_WAIT. On drv_done: pointer+1, → FETCH.
  - I_DELAY: count to payload×DLY_UNIT, then pointer+1, → FETCH.
  - Pointer wrap at 2^ROM_AW without an end marker: go to READY anyway.
- READY (busy = 0): when frame_req is high, latch the coordinates and pulse frame_ack.
  - If x1<x0 or y1<y0: also pulse frame_err and stay in READY.
  - Otherwise go to W_ISSUE.
  - frame_req is ignored in every other state.
- Window sequence, 11 words via W_ISSUE/W_WAIT with a word index 0..10:
  - idx 0x2A; data 0x00, x0, 0x00, x1
  - idx 0x2B; data 0x00, y0, 0x00, y1
  - idx 0x2C
- Pixel count = (x1−x0+1)×(y1−y0+1). It is 2·COORD_W+1 bits wide, is computed at acceptance, and its minimum is 1.
- Pixel loop:
  - P_IN: pix_ready = 1. On a handshake, latch pix_data and → P_HI.
  - P_HI: issue data pix[15:8] and wait for done.
  - P_LO: issue data pix[7:0] and wait for done.
  - Then decrement the count. If zero, pulse frame_done → READY; else → P_IN.
- pix_ready is high only in P_IN. A stalled source (pix_valid low) holds P_IN indefinitely with no driver activity.
- A drv_done that arrives outside a WAIT state is ignored.

Decomposition:
- Shared package lcd_pkg holds:
  - op codes OP_IDX, OP_DAT, OP_DLY, OP_END
  - command constants CMD_CASET 0x2A, CMD_PASET 0x2B, CMD_RAMWR 0x2C
  - the state enumeration
- Sub-module lcd_init_rom: a combinational case ROM, input addr [ROM_AW−1:0], output entry [10:0]. The panel script lives there, separate from the FSM.

Test Plan:
- Reset, with a ROM of {idx 0x01, dly 2, idx 0x11, data 0x05, end}, a behavioural driver (done 29 cycles after valid), DLY_UNIT=4 and RST_WAIT=10:
  - first drv_valid at cycle 11
  - 8-cycle gap after the first word's done
  - exactly three words total
  - init_done rises after the last done
- Frame with x0=2, x1=3, y0=5, y1=5:
  - 11 window words with the exact values and index/data flags
  - then pixels 0xF800 and 0x07E0 sent as data 0xF8, 0x00, 0x07, 0xE0
  - frame_done pulses once, busy falls
- Frame with x1=1, x0=4: frame_ack and frame_err pulse together, with no drv_valid.
- pix_valid held low for 50 cycles mid-frame: no drv_valid during the stall; the stream resumes correctly.
- frame_req asserted during init and during a frame: no frame_ack until READY.
- rst pulsed mid-pixel, with drv_done then arriving late:
  - all outputs 0 during reset
  - the init script restarts from entry 0
  - the stale done is ignored
